// File: rtl/uart_pkg.sv
// Shared types and bit-timing helpers for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int unsigned FRAME_BITS = 10;

  // Clock cycles per serial bit (integer division).
  function automatic int unsigned bit_period(input int unsigned clock_freq,
                                             input int unsigned baud_rate);
    return clock_freq / baud_rate;
  endfunction

  function automatic int unsigned baud_cnt_width(input int unsigned clock_freq,
                                                 input int unsigned baud_rate);
    return $clog2(bit_period(clock_freq, baud_rate));
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO buffering transmit data; power-of-two depth.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // Extra MSB on the pointers distinguishes full from empty.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: ready/valid byte input, FIFO buffer, registered serial output.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] DataIn,
  input  logic       DataInValid,
  output logic       DataInReady,
  output logic       SOut,
  output logic       Busy
);

  localparam int unsigned T    = bit_period(CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned CntW = baud_cnt_width(CLOCK_FREQ, BAUD_RATE);
  localparam logic [CntW-1:0] CntMax = CntW'(T - 1);

  if (T < 2) begin : g_bad_period
    $error("uart_transmitter: bit period CLOCK_FREQ/BAUD_RATE must be at least 2");
  end

  tx_state_t       state_q;
  logic [CntW-1:0] baud_cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            sout_q;

  logic       fifo_full, fifo_empty, fifo_pop, bit_done;
  logic [7:0] fifo_dout;

  assign bit_done = (baud_cnt_q == CntMax);
  // Pop when idle, or at the end of a stop bit so frames run back to back.
  assign fifo_pop = !fifo_empty && ((state_q == IDLE) || ((state_q == STOP) && bit_done));

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (DataInValid),
    .pop   (fifo_pop),
    .din   (DataIn),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      sout_q     <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          sout_q <= 1'b1;
          if (!fifo_empty) begin
            shift_q    <= fifo_dout;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            sout_q     <= 1'b0;
            state_q    <= START;
          end
        end
        START: begin
          if (bit_done) begin
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            sout_q     <= shift_q[0];
            state_q    <= DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (bit_done) begin
            baud_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              sout_q  <= 1'b1;
              state_q <= STOP;
            end else begin
              shift_q   <= shift_q >> 1;
              bit_idx_q <= bit_idx_q + 3'd1;
              sout_q    <= shift_q[1];
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (bit_done) begin
            baud_cnt_q <= '0;
            if (!fifo_empty) begin
              shift_q   <= fifo_dout;
              bit_idx_q <= '0;
              sout_q    <= 1'b0;
              state_q   <= START;
            end else begin
              sout_q  <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign SOut        = sout_q;
  assign DataInReady = !fifo_full;
  assign Busy        = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: accepted bytes queue expectations, a line monitor decodes.
module tb_uart_transmitter;
  import uart_pkg::*;

  localparam int unsigned T     = 10;  // 1000 / 100
  localparam int unsigned FRAME = FRAME_BITS * T;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] DataIn = 8'h00;
  logic       DataInValid = 1'b0;
  logic       DataInReady, SOut, Busy;

  always #5 clk = ~clk;

  uart_transmitter #(
    .CLOCK_FREQ (1000),
    .BAUD_RATE  (100),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .DataIn      (DataIn),
    .DataInValid (DataInValid),
    .DataInReady (DataInReady),
    .SOut        (SOut),
    .Busy        (Busy)
  );

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         frames = 0;
  int         acc_cyc = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Line monitor: every bit must hold for T cycles; decoded byte is checked against the queue.
  initial begin : monitor
    logic       active;
    int         pos;
    logic [9:0] mb;
    logic       unstable;
    active = 1'b0;
    pos = 0;
    mb = '0;
    unstable = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        active = 1'b0;
      end else begin
        if (!active && SOut === 1'b0) begin
          active = 1'b1;
          pos = 0;
          unstable = 1'b0;
          frames++;
          start_q.push_back(cyc);
        end
        if (active) begin
          if (pos % T == 0) mb[pos / T] = SOut;
          else if (SOut !== mb[pos / T]) unstable = 1'b1;
          pos++;
          if (pos == FRAME) begin
            active = 1'b0;
            check("frame_shape", {29'd0, unstable, mb[0], mb[9]}, 32'd1);
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_frame: actual=%0h required=none", mb[8:1]);
            end else begin
              check("frame_data", {24'd0, mb[8:1]}, {24'd0, exp_q.pop_front()});
            end
          end
        end
      end
    end
  end

  // Present a byte and wait (bounded) for the accept edge; returns just after that edge.
  task automatic send(input logic [7:0] b, output int waits);
    bit got;
    got = 1'b0;
    waits = 0;
    DataIn = b;
    DataInValid = 1'b1;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (DataInReady === 1'b1) got = 1'b1;
      else waits++;
      @(posedge clk);
    end
    if (got) begin
      exp_q.push_back(b);
      acc_cyc = cyc;
    end else begin
      total++;
      bad++;
      $display("FAIL accept_timeout: actual=none required=accept of %0h", b);
    end
    #1;
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    @(negedge clk);
    while (Busy !== 1'b0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", {31'd0, Busy}, 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int w, n, f0, base, w6, acc6, wsum;
    bit stray;
    repeat (3) @(negedge clk);
    check("reset_sout", {31'd0, SOut}, 32'd1);
    check("reset_ready", {31'd0, DataInReady}, 32'd1);
    check("reset_busy", {31'd0, Busy}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Single byte: latency and busy duration
    send(8'h55, w);
    DataInValid = 1'b0;
    @(negedge clk);
    check("latency_pre", {31'd0, SOut}, 32'd1);
    @(negedge clk);
    check("latency_fall", {31'd0, SOut}, 32'd0);
    n = 0;
    while (Busy === 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", n, 100);

    // Reset mid-frame with a second byte still buffered
    repeat (5) @(posedge clk);
    #1;
    send(8'hC4, w);
    send(8'h99, w);
    DataInValid = 1'b0;
    f0 = frames;
    repeat (35) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_sout", {31'd0, SOut}, 32'd1);
    check("midreset_ready", {31'd0, DataInReady}, 32'd1);
    check("midreset_busy", {31'd0, Busy}, 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (SOut !== 1'b1) stray = 1'b1;
    end
    check("no_bits_after_reset", {31'd0, stray}, 32'd0);
    check("frames_after_reset", frames - f0, 1);

    // Back-to-back frames with no idle gap
    @(posedge clk);
    #1;
    base = start_q.size();
    send(8'hA3, w);
    send(8'h0F, w);
    DataInValid = 1'b0;
    wait_idle(3000);
    check("b2b_frames", start_q.size() - base, 2);
    check("b2b_gap", start_q[base+1] - start_q[base], FRAME);

    // Fill the FIFO; byte 6 is refused on the pop edge and taken the next cycle
    @(posedge clk);
    #1;
    base = start_q.size();
    wsum = 0;
    for (int b = 1; b <= 5; b++) begin
      send(8'(b), w);
      wsum += w;
    end
    check("fill_no_wait", wsum, 0);
    send(8'h06, w6);
    acc6 = acc_cyc;
    DataInValid = 1'b0;
    check("byte6_waits", w6, 97);
    wait_idle(3000);
    check("full_frames", start_q.size() - base, 6);
    check("push_after_pop", acc6, start_q[base+1]);

    // DataIn change after accept must not affect the queued byte
    @(posedge clk);
    #1;
    send(8'h3C, w);
    DataIn = 8'hFF;
    DataInValid = 1'b0;
    wait_idle(3000);
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
